// File: rtl/fpu_i2f_sched.sv
// fpu_i2f_sched: two-requester scheduler for the shared int-to-float datapath.
// It grants requests round-robin, resolves dynamic rounding against frm, and runs
// the converter for one cycle per operation. It holds a registered response until
// the consumer accepts it.
// Ports:
//   clk, rst_l           - clock, synchronous active-low reset
//   reqN_valid/ready     - request handshake (N=0,1); ready is combinational
//   reqN_int/rm/signed/tag - operand, rounding mode (111=dynamic), W/WU, tag
//   frm                  - FCSR rounding mode, sampled at grant
//   resp_valid/ready     - response handshake
//   resp_float/inexact/invalid/rm_err/tag/src - registered response fields
//   fflags_nx, flag_clr  - sticky inexact flag and its clear
//   busy                 - controller is not idle
module fpu_i2f_sched #(
    parameter int std  = 31,
    parameter int man  = 22,
    parameter int exp  = 7,
    parameter int bias = 127,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [31:0]     req0_int,
    input  logic [2:0]      req0_rm,
    input  logic            req0_signed,
    input  logic [TAGW-1:0] req0_tag,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [31:0]     req1_int,
    input  logic [2:0]      req1_rm,
    input  logic            req1_signed,
    input  logic [TAGW-1:0] req1_tag,
    input  logic [2:0]      frm,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [std:0]    resp_float,
    output logic            resp_inexact,
    output logic            resp_invalid,
    output logic            resp_rm_err,
    output logic [TAGW-1:0] resp_tag,
    output logic            resp_src,
    output logic            fflags_nx,
    input  logic            flag_clr,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          state_q;
    logic            rr_q;
    logic [31:0]     op_q;
    logic            signed_q;
    logic [2:0]      rm_q;
    logic            rmErr_q;
    logic            respValid_q;
    logic [std:0]    respFloat_q;
    logic            respNx_q;
    logic            respInv_q;
    logic            respRmErr_q;
    logic [TAGW-1:0] respTag_q;
    logic            respSrc_q;
    logic            fflagsNx_q;

    logic            anyValid_d;
    logic            grant1_d;
    logic [2:0]      selRm_d;
    logic [2:0]      effRm_d;
    logic            rmErr_d;
    logic            execActive;
    logic [std:0]    cvtFloat;
    logic            cvtNx;
    logic            cvtInv;

    // Arbitration: a lone requester always wins; with both valid, rr_q picks.
    // Dynamic rounding (111) is replaced by frm before the legality check.
    always_comb begin
        anyValid_d = req0_valid | req1_valid;
        grant1_d   = req1_valid & (~req0_valid | rr_q);
        selRm_d    = grant1_d ? req1_rm : req0_rm;
        effRm_d    = (selRm_d == 3'b111) ? frm : selRm_d;
        rmErr_d    = effRm_d inside {3'b101, 3'b110, 3'b111};
    end

    // Ready is gated by rst_l so nothing is accepted while reset is held.
    assign req0_ready = rst_l & (state_q == IDLE) & req0_valid & ~grant1_d;
    assign req1_ready = rst_l & (state_q == IDLE) & grant1_d;
    assign execActive = (state_q == EXEC);

    FPU_Int_to_Float #(
        .std (std),
        .man (man),
        .exp (exp),
        .bias(bias)
    ) u_cvt (
        .opcode_IF      (execActive),
        .opcode_signed  (execActive & signed_q),
        .opcode_unsigned(execActive & ~signed_q),
        .rm             (rm_q),
        .int_in         (op_q),
        .float_out      (cvtFloat),
        .inexact        (cvtNx),
        .invalid        (cvtInv)
    );

    // Controller FSM with all response fields and the sticky flag registered.
    // On a handshake that coincides with flag_clr, the clear wins first and the
    // new inexact bit is then ORed in.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            op_q        <= '0;
            signed_q    <= 1'b0;
            rm_q        <= '0;
            rmErr_q     <= 1'b0;
            respValid_q <= 1'b0;
            respFloat_q <= '0;
            respNx_q    <= 1'b0;
            respInv_q   <= 1'b0;
            respRmErr_q <= 1'b0;
            respTag_q   <= '0;
            respSrc_q   <= 1'b0;
            fflagsNx_q  <= 1'b0;
        end else begin
            if (respValid_q & resp_ready)
                fflagsNx_q <= (fflagsNx_q & ~flag_clr) | respNx_q;
            else if (flag_clr)
                fflagsNx_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (anyValid_d) begin
                        op_q      <= grant1_d ? req1_int    : req0_int;
                        signed_q  <= grant1_d ? req1_signed : req0_signed;
                        respTag_q <= grant1_d ? req1_tag    : req0_tag;
                        respSrc_q <= grant1_d;
                        rm_q      <= effRm_d;
                        rmErr_q   <= rmErr_d;
                        rr_q      <= ~grant1_d;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    respFloat_q <= rmErr_q ? '0 : cvtFloat;
                    respNx_q    <= ~rmErr_q & cvtNx;
                    respInv_q   <= ~rmErr_q & cvtInv;
                    respRmErr_q <= rmErr_q;
                    respValid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        respValid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid   = respValid_q;
    assign resp_float   = respFloat_q;
    assign resp_inexact = respNx_q;
    assign resp_invalid = respInv_q;
    assign resp_rm_err  = respRmErr_q;
    assign resp_tag     = respTag_q;
    assign resp_src     = respSrc_q;
    assign fflags_nx    = fflagsNx_q;
    assign busy         = (state_q != IDLE);

endmodule

// FPU_Int_to_Float: combinational 32-bit integer to float conversion.
// Ports: opcode_IF enables the unit (outputs zero otherwise), opcode_signed /
// opcode_unsigned select W / WU, rm is the resolved IEEE rounding mode, int_in
// is the operand; float_out, inexact and invalid are the results. invalid
// flags an inconsistent signed/unsigned opcode pair.
module FPU_Int_to_Float #(
    parameter int std  = 31,
    parameter int man  = 22,
    parameter int exp  = 7,
    parameter int bias = 127
) (
    input  logic          opcode_IF,
    input  logic          opcode_signed,
    input  logic          opcode_unsigned,
    input  logic [2:0]    rm,
    input  logic [31:0]   int_in,
    output logic [std:0]  float_out,
    output logic          inexact,
    output logic          invalid
);

    localparam int MW = man + 1;
    localparam int EW = exp + 1;

    logic          sign;
    logic [31:0]   mag;
    logic [31:0]   norm;
    logic [31:0]   lowBits;
    logic [4:0]    lz;
    logic          guard;
    logic          sticky;
    logic          lsb;
    logic          inc;
    logic [MW+1:0] rounded;
    logic [EW-1:0] expField;

    // Normalise the magnitude so its leading one sits at bit 31, round the
    // kept bits, and bump the exponent if rounding carried out of the mantissa.
    // rounded holds {carry, hidden, fraction}; both top bits clear means zero.
    always_comb begin
        sign = opcode_signed & int_in[31];
        mag  = sign ? (~int_in + 32'd1) : int_in;
        lz   = '0;
        for (int i = 0; i < 32; i++)
            if (mag[i]) lz = 5'(31 - i);
        norm    = mag << lz;
        guard   = norm[30-MW];
        lowBits = norm << (MW + 2);
        sticky  = |lowBits;
        lsb     = norm[31-MW];
        case (rm)
            3'b000:  inc = guard & (sticky | lsb);
            3'b010:  inc = sign & (guard | sticky);
            3'b011:  inc = ~sign & (guard | sticky);
            3'b100:  inc = guard;
            default: inc = 1'b0;
        endcase
        rounded  = {1'b0, norm[31 -: MW+1]} + {{(MW+1){1'b0}}, inc};
        expField = EW'(bias + 31 - int'(lz) + int'(rounded[MW+1]));
        if (!opcode_IF || rounded[MW+1:MW] == 2'b00)
            float_out = '0;
        else
            float_out = {sign, expField, rounded[MW-1:0]};
        inexact = opcode_IF & (guard | sticky);
        invalid = opcode_IF & ~(opcode_signed ^ opcode_unsigned);
    end

endmodule
